cond_select_arb: RTL and testbench
==================================

# cond_select_arb

Registered N-way condition selector that implements priority, unique and unique0 selection semantics in hardware, with violation detection. It accepts a vector of condition hits through a valid/ready handshake and returns a one-hot grant, or an "else" indication when no condition hits. It also keeps saturating violation counters and a sticky error flag. It sits between condition-generating logic and the consumer of the selected branch, and is the checkable, synthesizable successor to ad-hoc `unique if` / `priority if` chains.

## Interface
- `N`, 4: number of condition channels, 2..32.
- `MODE`, 0: 0 = priority, 1 = unique, 2 = unique0.
- `HAS_ELSE`, 1: 1 = a no-hit is legal (else branch); 0 = no else branch.
- `CNT_W`, 8: width of the violation counters.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_i`  in  N  condition hit vector; bit i = condition i true.
- `req_valid_i`  in  1  `req_i` is valid.
- `req_ready_o`  out  1  block can accept a request.
- `gnt_o`  out  N  one-hot grant; all zero on no-hit.
- `gnt_idx_o`  out  $clog2(N)  index of the granted channel; 0 on no-hit.
- `none_o`  out  1  no condition hit (else branch taken).
- `gnt_valid_o`  out  1  result valid.
- `gnt_ready_i`  in  1  consumer accepts the result.
- `multi_err_o`  out  1  more than one hit on the current result (MODE 1/2 only).
- `none_err_o`  out  1  no hit while an else branch is required (MODE 0/1 with `HAS_ELSE`=0).
- `err_sticky_o`  out  1  set by any violation; cleared only by `err_clr_i`.
- `err_clr_i`  in  1  synchronous clear of the sticky flag and both counters.
- `multi_cnt_o`  out  CNT_W  saturating count of multi-hit violations.
- `none_cnt_o`  out  CNT_W  saturating count of no-hit violations.

## Operation
- Single output register stage.
  - `req_ready_o = !gnt_valid_o || gnt_ready_i`.
  - A request is accepted when `req_valid_i && req_ready_o`.
- On accept, the result registers load as follows:
  - popcount(`req_i`) = 1: grant that bit.
  - popcount > 1, MODE 0: grant the lowest set index. This is legal and raises no error.
  - popcount > 1, MODE 1 or 2: grant the lowest set index and set `multi_err_o`=1.
  - popcount = 0: `gnt_o`=0, `gnt_idx_o`=0, `none_o`=1.
    - `none_err_o`=1 iff `HAS_ELSE`=0 and MODE is 0 or 1.
    - MODE 2 never flags a no-hit.
- Result fields and the error flags hold while `gnt_valid_o && !gnt_ready_i`.
- Back-to-back accepts are allowed every cycle at full throughput.
- When the result is consumed and no new request is accepted in the same cycle:
  - `gnt_valid_o` clears.
  - `multi_err_o` and `none_err_o` clear.
- Each violation increments its counter once per accepted request, not per held cycle.
- Counters saturate at 2^CNT_W−1.
- `err_sticky_o` is set on any violation.
- `err_clr_i` in the same cycle as a new violation: the clear applies first, then the increment.
  - The counter becomes 1.
  - The sticky flag stays 1.
- Reset values: `gnt_valid_o`=0, `gnt_o`=0, `gnt_idx_o`=0, `none_o`=0, `multi_err_o`=0, `none_err_o`=0, `err_sticky_o`=0, both counters=0.
  - `req_ready_o`=1 after reset, as a combinational consequence of `gnt_valid_o`=0.
- Reset asserted mid-transaction discards any pending result immediately, without waiting for a clock edge.

## Timing
- Latency: 1 cycle from the accept edge to `gnt_valid_o` and all result fields.
- `multi_err_o`/`none_err_o` are registered with the result and valid only while `gnt_valid_o`=1.
- The counters and `err_sticky_o` update on the accept edge, visible the next cycle.
- The only combinational path is `gnt_ready_i` → `req_ready_o`.
- Static invariants:
  - `gnt_o` is one-hot or zero.
  - `none_o` = (`gnt_o` == 0) whenever `gnt_valid_o`=1.

## Configuration
- `COND_SEL_RR_EN`
  - Defined: in MODE 1/2, a multi-hit grants the first set bit at or after (last granted index + 1) mod N.
    - The rotation pointer updates only on single-hit or multi-hit grants.
    - The pointer resets to N−1, so the first search starts at 0.
    - Errors are still flagged.
  - Undefined: lowest-index grant in all modes and no pointer register.
  - MODE 0 is always lowest-index regardless of the macro.

## Test plan
- MODE 0, N=4, `req_i`=4'b0110 → `gnt_o`=4'b0010, `gnt_idx_o`=1, `multi_err_o`=0, counters unchanged.
- MODE 1, `HAS_ELSE`=0:
  - 4'b0000 → `none_o`=1, `none_err_o`=1, `none_cnt_o`=1, `err_sticky_o`=1.
  - Then 4'b1010 → `gnt_o`=4'b0010 (4'b1000 if `COND_SEL_RR_EN` is defined, with the pointer at 1 from a preceding grant), `multi_err_o`=1, `multi_cnt_o`=1.
- MODE 2, `HAS_ELSE`=0, `req_i`=0 → `none_o`=1 with `none_err_o`=0 and `none_cnt_o`=0.
- Backpressure:
  - `gnt_ready_i`=0 for 3 cycles after an accept → result and error flags stable, `req_ready_o`=0, counter incremented exactly once.
- Saturation and clear, `CNT_W`=2, MODE 1:
  - Five multi-hits → `multi_cnt_o`=3.
  - `err_clr_i` together with a new multi-hit → `multi_cnt_o`=1, `err_sticky_o`=1.
- Async reset asserted while `gnt_valid_o`=1 → all outputs at their reset values before the next clock edge; the first request after release has 1-cycle latency.

Source files
------------

// File: rtl/cond_select_arb.sv
// Registered N-way condition selector with priority/unique/unique0 semantics and violation tracking.
// Optional feature: define COND_SEL_RR_EN for round-robin multi-hit resolution in MODE 1/2.
module cond_select_arb #(
  parameter int N        = 4,
  parameter int MODE     = 0,
  parameter int HAS_ELSE = 1,
  parameter int CNT_W    = 8,
  localparam int IdxW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic [N-1:0]     gnt_o,
  output logic [IdxW-1:0]  gnt_idx_o,
  output logic             none_o,
  output logic             gnt_valid_o,
  input  logic             gnt_ready_i,
  output logic             multi_err_o,
  output logic             none_err_o,
  output logic             err_sticky_o,
  input  logic             err_clr_i,
  output logic [CNT_W-1:0] multi_cnt_o,
  output logic [CNT_W-1:0] none_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             gnt_valid_q;
  logic [N-1:0]     gnt_q;
  logic [IdxW-1:0]  gnt_idx_q;
  logic             none_q;
  logic             multi_err_q;
  logic             none_err_q;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] multi_cnt_q, multi_cnt_d;
  logic [CNT_W-1:0] none_cnt_q, none_cnt_d;

  logic             accept;
  logic             any_hit;
  logic             multi_hit;
  logic             viol_multi;
  logic             viol_none;
  logic [IdxW-1:0]  low_idx;
  logic [IdxW-1:0]  sel_idx;
  logic [N-1:0]     sel_oh;
  logic [CNT_W-1:0] multi_base;
  logic [CNT_W-1:0] none_base;

`ifdef COND_SEL_RR_EN
  logic [IdxW-1:0]  ptr_q;
  logic [IdxW-1:0]  rr_idx;
  logic [IdxW-1:0]  pos_idx;
  logic             rr_found;
  int               pos;
`endif

  assign req_ready_o = !gnt_valid_q || gnt_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    any_hit   = |req_i;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    multi_hit = |(req_i & (req_i - N'(1)));
    low_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) low_idx = IdxW'(i);
    end

`ifdef COND_SEL_RR_EN
    rr_idx   = low_idx;
    rr_found = 1'b0;
    pos      = 0;
    pos_idx  = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_q) + 1 + k;
      if (pos >= N) pos = pos - N;
      pos_idx = pos[IdxW-1:0];
      if (!rr_found && req_i[pos_idx]) begin
        rr_found = 1'b1;
        rr_idx   = pos_idx;
      end
    end
    sel_idx = (MODE != 0) ? rr_idx : low_idx;
`else
    sel_idx = low_idx;
`endif

    sel_oh = '0;
    if (any_hit) sel_oh[sel_idx] = 1'b1;

    viol_multi = (MODE != 0) && multi_hit;
    viol_none  = !any_hit && (HAS_ELSE == 0) && (MODE != 2);

    // Clear takes effect before the increment of a coincident violation.
    multi_base  = err_clr_i ? '0 : multi_cnt_q;
    none_base   = err_clr_i ? '0 : none_cnt_q;
    multi_cnt_d = multi_base;
    none_cnt_d  = none_base;
    if (accept && viol_multi && (multi_base != CntMax)) multi_cnt_d = multi_base + CNT_W'(1);
    if (accept && viol_none && (none_base != CntMax)) none_cnt_d = none_base + CNT_W'(1);

    sticky_d = err_clr_i ? 1'b0 : sticky_q;
    if (accept && (viol_multi || viol_none)) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_valid_q <= 1'b0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      none_q      <= 1'b0;
      multi_err_q <= 1'b0;
      none_err_q  <= 1'b0;
    end else if (accept) begin
      gnt_valid_q <= 1'b1;
      gnt_q       <= sel_oh;
      gnt_idx_q   <= any_hit ? sel_idx : '0;
      none_q      <= !any_hit;
      multi_err_q <= viol_multi;
      none_err_q  <= viol_none;
    end else if (gnt_ready_i) begin
      gnt_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
      none_err_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q    <= 1'b0;
      multi_cnt_q <= '0;
      none_cnt_q  <= '0;
    end else begin
      sticky_q    <= sticky_d;
      multi_cnt_q <= multi_cnt_d;
      none_cnt_q  <= none_cnt_d;
    end
  end

`ifdef COND_SEL_RR_EN
  // Pointer starts at N-1 so the first search begins at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IdxW'(N - 1);
    end else if (accept && any_hit) begin
      ptr_q <= sel_idx;
    end
  end
`endif

  assign gnt_valid_o  = gnt_valid_q;
  assign gnt_o        = gnt_q;
  assign gnt_idx_o    = gnt_idx_q;
  assign none_o       = none_q;
  assign multi_err_o  = multi_err_q;
  assign none_err_o   = none_err_q;
  assign err_sticky_o = sticky_q;
  assign multi_cnt_o  = multi_cnt_q;
  assign none_cnt_o   = none_cnt_q;

endmodule

// File: tb/tb_cond_select_arb.sv
// Bench for cond_select_arb: three instances (MODE 0/1/2) share one stimulus stream and a scoreboard.
module tb_cond_select_arb;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       none;
    logic       merr;
    logic       nerr;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       req_valid = 1'b0;
  logic       gnt_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       rdy0, rdy1, rdy2, gv0, gv1, gv2;
  logic [3:0] g0, g1, g2;
  logic [1:0] ix0, ix1, ix2;
  logic       nn0, nn1, nn2, me0, me1, me2, ne0, ne1, ne2, st0, st1, st2;
  logic [7:0] mc0, nc0, mc2, nc2;
  logic [1:0] mc1, nc1;

  int   mode_of [3] = '{0, 1, 2};
  int   else_of [3] = '{1, 0, 0};
  int   max_of  [3] = '{255, 3, 255};
  int   mcnt [3];
  int   ncnt [3];
  logic stk  [3];
  int   ptr  [3];
  res_t cur  [3];
  res_t sb_q [$];
  logic exp_valid;
  logic rst_chk;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cond_select_arb #(.N(4), .MODE(0), .HAS_ELSE(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_valid_i(req_valid), .req_ready_o(rdy0),
    .gnt_o(g0), .gnt_idx_o(ix0), .none_o(nn0), .gnt_valid_o(gv0), .gnt_ready_i(gnt_ready),
    .multi_err_o(me0), .none_err_o(ne0), .err_sticky_o(st0), .err_clr_i(err_clr),
    .multi_cnt_o(mc0), .none_cnt_o(nc0)
  );

  cond_select_arb #(.N(4), .MODE(1), .HAS_ELSE(0), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_valid_i(req_valid), .req_ready_o(rdy1),
    .gnt_o(g1), .gnt_idx_o(ix1), .none_o(nn1), .gnt_valid_o(gv1), .gnt_ready_i(gnt_ready),
    .multi_err_o(me1), .none_err_o(ne1), .err_sticky_o(st1), .err_clr_i(err_clr),
    .multi_cnt_o(mc1), .none_cnt_o(nc1)
  );

  cond_select_arb #(.N(4), .MODE(2), .HAS_ELSE(0), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_valid_i(req_valid), .req_ready_o(rdy2),
    .gnt_o(g2), .gnt_idx_o(ix2), .none_o(nn2), .gnt_valid_o(gv2), .gnt_ready_i(gnt_ready),
    .multi_err_o(me2), .none_err_o(ne2), .err_sticky_o(st2), .err_clr_i(err_clr),
    .multi_cnt_o(mc2), .none_cnt_o(nc2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input int k, input logic [3:0] r);
    res_t e;
    int   cnt;
    int   sel;
    cnt = $countones(r);
    sel = 0;
    for (int i = 3; i >= 0; i--) if (r[i]) sel = i;
`ifdef COND_SEL_RR_EN
    if (mode_of[k] != 0 && cnt > 1) begin
      for (int j = 4; j >= 1; j--) if (r[(ptr[k] + j) % 4]) sel = (ptr[k] + j) % 4;
    end
`endif
    e.gnt  = (cnt != 0) ? 4'(1 << sel) : 4'b0000;
    e.idx  = (cnt != 0) ? 2'(sel) : 2'd0;
    e.none = (cnt == 0);
    e.merr = (mode_of[k] != 0) && (cnt > 1);
    e.nerr = (cnt == 0) && (else_of[k] == 0) && (mode_of[k] != 2);
    return e;
  endfunction

  task automatic check_inst(input int k, input logic gv, input logic [3:0] g, input logic [1:0] ix,
                            input logic nn, input logic me, input logic ne, input logic st,
                            input logic [7:0] mc, input logic [7:0] nc);
    chk($sformatf("u%0d.gnt_valid", k), 32'(gv), 32'(exp_valid));
    if (exp_valid) begin
      chk($sformatf("u%0d.gnt", k), 32'(g), 32'(cur[k].gnt));
      chk($sformatf("u%0d.gnt_idx", k), 32'(ix), 32'(cur[k].idx));
      chk($sformatf("u%0d.none", k), 32'(nn), 32'(cur[k].none));
      chk($sformatf("u%0d.multi_err", k), 32'(me), 32'(cur[k].merr));
      chk($sformatf("u%0d.none_err", k), 32'(ne), 32'(cur[k].nerr));
    end else begin
      chk($sformatf("u%0d.multi_err_idle", k), 32'(me), 32'd0);
      chk($sformatf("u%0d.none_err_idle", k), 32'(ne), 32'd0);
    end
    if (rst_chk) begin
      chk($sformatf("u%0d.gnt_rst", k), 32'(g), 32'd0);
      chk($sformatf("u%0d.idx_rst", k), 32'(ix), 32'd0);
      chk($sformatf("u%0d.none_rst", k), 32'(nn), 32'd0);
    end
    chk($sformatf("u%0d.sticky", k), 32'(st), 32'(stk[k]));
    chk($sformatf("u%0d.multi_cnt", k), 32'(mc), 32'(mcnt[k]));
    chk($sformatf("u%0d.none_cnt", k), 32'(nc), 32'(ncnt[k]));
  endtask

  task automatic check_all();
    check_inst(0, gv0, g0, ix0, nn0, me0, ne0, st0, mc0, nc0);
    check_inst(1, gv1, g1, ix1, nn1, me1, ne1, st1, {6'b0, mc1}, {6'b0, nc1});
    check_inst(2, gv2, g2, ix2, nn2, me2, ne2, st2, mc2, nc2);
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    sb_q.delete();
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      ncnt[k] = 0;
      stk[k]  = 1'b0;
      ptr[k]  = 3;
      cur[k]  = '0;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic v, input logic rdy, input logic clr);
    logic acc;
    logic exp_rdy;
    res_t e;
    req = r;
    req_valid = v;
    gnt_ready = rdy;
    err_clr = clr;
    #1;
    exp_rdy = !exp_valid || rdy;
    acc = v && exp_rdy;
    chk("u0.req_ready", 32'(rdy0), 32'(exp_rdy));
    chk("u1.req_ready", 32'(rdy1), 32'(exp_rdy));
    chk("u2.req_ready", 32'(rdy2), 32'(exp_rdy));
    for (int k = 0; k < 3; k++) begin
      e = model(k, r);
      if (clr) begin
        mcnt[k] = 0;
        ncnt[k] = 0;
        stk[k]  = 1'b0;
      end
      if (acc) begin
        sb_q.push_back(e);
        if (e.merr && mcnt[k] < max_of[k]) mcnt[k]++;
        if (e.nerr && ncnt[k] < max_of[k]) ncnt[k]++;
        if (e.merr || e.nerr) stk[k] = 1'b1;
        if (!e.none) ptr[k] = int'(e.idx);
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      exp_valid = 1'b1;
      for (int k = 0; k < 3; k++) cur[k] = sb_q.pop_front();
    end else if (rdy) begin
      exp_valid = 1'b0;
    end
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_chk = 1'b1;
    #12;
    check_all();
    chk("u0.req_ready_rst", 32'(rdy0), 32'd1);
    rst_chk = 1'b0;
    rst_n = 1'b1;

    // Priority/unique/unique0 basics, then the unique multi-hit after a no-hit.
    step(4'b0110, 1, 1, 0);
    step(4'b0000, 1, 1, 0);
    step(4'b1010, 1, 1, 0);

    // Backpressure: accept, hold three cycles, then drain and go idle.
    step(4'b0101, 1, 0, 0);
    step(4'b1111, 1, 0, 0);
    step(4'b0000, 1, 0, 0);
    step(4'b0011, 1, 0, 0);
    step(4'b0000, 0, 1, 0);
    step(4'b0000, 0, 1, 0);

    for (int i = 0; i < 4; i++) step(4'(1 << i), 1, 1, 0);

    // Saturation of the 2-bit counter, then clear coinciding with a violation.
    for (int i = 0; i < 5; i++) step(4'b1111, 1, 1, 0);
    step(4'b0011, 1, 1, 1);
    step(4'b0001, 1, 1, 1);
    step(4'b0000, 1, 1, 0);

    for (int i = 0; i < 24; i++) begin
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0));
    end

    // Async reset with a result pending.
    step(4'b1100, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_chk = 1'b1;
    check_all();
    chk("u1.req_ready_rst", 32'(rdy1), 32'd1);
    rst_chk = 1'b0;
    #1;
    rst_n = 1'b1;
    step(4'b0100, 1, 1, 0);
    step(4'b1001, 1, 1, 0);
    step(4'b0000, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
